// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch squash, and
// hold of multi-cycle custom-IP ops in ID with a start/ready/done handshake.
module hazard_stall_ctrl #(
   parameter int RA_W       = 5,
   parameter int IP_TIMEOUT = 255,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [RA_W-1:0]  rs1_ID,
   input  logic [RA_W-1:0]  rs2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [RA_W-1:0]  rd_EX,
   input  logic             memread_EX,
   input  logic             branch_taken_EX,
   input  logic             ip_op_ID,
   input  logic             ip_ready,
   input  logic             ip_done,
   output logic             ip_start,
   output logic             stall_PC,
   output logic             stall_IFID,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic             ip_timeout,
   output logic [1:0]       state_dbg,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {RUN = 2'd0, IP_REQ = 2'd1, IP_WAIT = 2'd2} state_t;

   localparam int TW = (IP_TIMEOUT <= 2) ? 1 : $clog2(IP_TIMEOUT);

   state_t        state;
   logic [TW-1:0] cnt;
   logic          load_use;
   logic          in_ip;
   logic          tmo_hit;

   assign load_use = memread_EX && (rd_EX != '0) &&
                     ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                      (use_rs2_ID && (rs2_ID == rd_EX)));

   assign in_ip   = (state == IP_REQ) || (state == IP_WAIT);
   // A done in IP_WAIT wins over the timeout in the same cycle.
   assign tmo_hit = in_ip && (cnt == TW'(IP_TIMEOUT - 1)) &&
                    !((state == IP_WAIT) && ip_done);

   // Gated with RST so nothing leaks out combinationally while in reset.
   always_comb begin
      ip_start   = 1'b0;
      stall_PC   = 1'b0;
      stall_IFID = 1'b0;
      flush_IFID = 1'b0;
      flush_IDEX = 1'b0;
      if (!RST) begin
         case (state)
            RUN: begin
               if (branch_taken_EX) begin
                  flush_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end else if (load_use || ip_op_ID) begin
                  stall_PC   = 1'b1;
                  stall_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end
            end
            IP_REQ: begin
               if (!tmo_hit) begin
                  ip_start   = 1'b1;
                  stall_PC   = 1'b1;
                  stall_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end
            end
            IP_WAIT: begin
               if (!ip_done && !tmo_hit) begin
                  stall_PC   = 1'b1;
                  stall_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= RUN;
         cnt        <= '0;
         ip_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!branch_taken_EX && !load_use && ip_op_ID) begin
                  state <= IP_REQ;
                  cnt   <= '0;
               end
            end
            IP_REQ: begin
               cnt <= cnt + TW'(1);
               if (tmo_hit) begin
                  state      <= RUN;
                  ip_timeout <= 1'b1;
               end else if (ip_ready) begin
                  state <= IP_WAIT;
               end
            end
            IP_WAIT: begin
               cnt <= cnt + TW'(1);
               if (ip_done) begin
                  state <= RUN;
               end else if (tmo_hit) begin
                  state      <= RUN;
                  ip_timeout <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         stall_cycles <= '0;
      else if (stall_IFID && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch priority, IP handshake,
// timeout, async reset and counter saturation, with hand-computed expectations.
module tb_hazard_stall_ctrl;

   localparam int RA_W       = 5;
   localparam int IP_TIMEOUT = 8;
   localparam int CNT_W      = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [RA_W-1:0]  rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
   logic             use_rs1_ID = 0, use_rs2_ID = 0, memread_EX = 0;
   logic             branch_taken_EX = 0, ip_op_ID = 0, ip_ready = 0, ip_done = 0;
   logic             ip_start, stall_PC, stall_IFID, flush_IFID, flush_IDEX, ip_timeout;
   logic [1:0]       state_dbg;
   logic [CNT_W-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   hazard_stall_ctrl #(.RA_W(RA_W), .IP_TIMEOUT(IP_TIMEOUT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .rd_EX(rd_EX), .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
      .ip_op_ID(ip_op_ID), .ip_ready(ip_ready), .ip_done(ip_done),
      .ip_start(ip_start), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
      .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .ip_timeout(ip_timeout),
      .state_dbg(state_dbg), .stall_cycles(stall_cycles)
   );

   always #5 CLK = ~CLK;

   // {ip_start, stall_PC, stall_IFID, flush_IFID, flush_IDEX}
   logic [4:0] ctl;
   assign ctl = {ip_start, stall_PC, stall_IFID, flush_IFID, flush_IDEX};

   localparam logic [4:0] C_NONE  = 5'b00000;
   localparam logic [4:0] C_STALL = 5'b01101;
   localparam logic [4:0] C_REQ   = 5'b11101;
   localparam logic [4:0] C_FLUSH = 5'b00011;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_in();
      rs1_ID = '0; rs2_ID = '0; rd_EX = '0; use_rs1_ID = 0; use_rs2_ID = 0;
      memread_EX = 0; branch_taken_EX = 0; ip_op_ID = 0; ip_ready = 0; ip_done = 0;
   endtask

   task automatic do_reset();
      clear_in();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_NONE));
      chk("rst_state", 32'(state_dbg), 0);
      chk("rst_tmo", 32'(ip_timeout), 0);
      chk("rst_cnt", 32'(stall_cycles), 0);
      tick();
      RST = 1'b0;

      // T1 load-use on rs1
      memread_EX = 1; rd_EX = 3; rs1_ID = 3; use_rs1_ID = 1;
      #1 chk("t1_lu_rs1", 32'(ctl), 32'(C_STALL));
      tick();
      clear_in();
      #1 chk("t1_bubble", 32'(ctl), 32'(C_NONE));
      chk("t1_cnt", 32'(stall_cycles), 1);
      memread_EX = 1; rd_EX = 0; rs1_ID = 0; use_rs1_ID = 1;
      #1 chk("t1_rd0", 32'(ctl), 32'(C_NONE));
      rd_EX = 3; rs1_ID = 3; use_rs1_ID = 0;
      #1 chk("t1_nouse", 32'(ctl), 32'(C_NONE));
      use_rs2_ID = 1; rs2_ID = 3;
      #1 chk("t1_lu_rs2", 32'(ctl), 32'(C_STALL));
      tick();
      clear_in();
      #1 chk("t1_cnt2", 32'(stall_cycles), 2);

      // T2 branch beats load-use
      branch_taken_EX = 1; memread_EX = 1; rd_EX = 4; rs1_ID = 4; use_rs1_ID = 1;
      #1 chk("t2_flush", 32'(ctl), 32'(C_FLUSH));
      tick();
      clear_in();
      #1 chk("t2_state", 32'(state_dbg), 0);
      chk("t2_cnt", 32'(stall_cycles), 2);

      // T3 IP op: ready at cycle 3, done at cycle 7
      do_reset();
      ip_op_ID = 1;
      #1 chk("t3_c0", 32'(ctl), 32'(C_STALL));
      chk("t3_c0_st", 32'(state_dbg), 0);
      tick();
      for (int c = 1; c <= 3; c++) begin
         ip_ready = (c == 3);
         #1 chk($sformatf("t3_c%0d", c), 32'(ctl), 32'(C_REQ));
         chk($sformatf("t3_c%0d_st", c), 32'(state_dbg), 1);
         tick();
      end
      ip_ready = 0;
      for (int c = 4; c <= 6; c++) begin
         #1 chk($sformatf("t3_c%0d", c), 32'(ctl), 32'(C_STALL));
         chk($sformatf("t3_c%0d_st", c), 32'(state_dbg), 2);
         tick();
      end
      ip_done = 1;
      #1 chk("t3_c7", 32'(ctl), 32'(C_NONE));
      tick();
      clear_in();
      #1 chk("t3_end_st", 32'(state_dbg), 0);
      chk("t3_end_ctl", 32'(ctl), 32'(C_NONE));
      chk("t3_cnt", 32'(stall_cycles), 7);
      chk("t3_tmo", 32'(ip_timeout), 0);

      // T4 timeout: ip_done never comes
      do_reset();
      ip_op_ID = 1;
      #1 chk("t4_c0", 32'(ctl), 32'(C_STALL));
      tick();
      ip_op_ID = 0;
      for (int c = 1; c <= 7; c++) begin
         ip_ready = (c == 2);
         #1 chk($sformatf("t4_c%0d_stall", c), 32'(stall_IFID), 1);
         tick();
      end
      ip_ready = 0;
      #1 chk("t4_c8_rel", 32'(ctl), 32'(C_NONE));
      chk("t4_c8_tmo", 32'(ip_timeout), 0);
      tick();
      #1 chk("t4_tmo", 32'(ip_timeout), 1);
      chk("t4_state", 32'(state_dbg), 0);
      chk("t4_cnt", 32'(stall_cycles), 8);
      tick(); tick();
      #1 chk("t4_sticky", 32'(ip_timeout), 1);

      // T5 branch kills IP op in ID
      branch_taken_EX = 1; ip_op_ID = 1;
      #1 chk("t5_flush", 32'(ctl), 32'(C_FLUSH));
      tick();
      clear_in();
      #1 chk("t5_state", 32'(state_dbg), 0);
      chk("t5_start", 32'(ip_start), 0);

      // T6 async reset in IP_WAIT, then counter saturation
      ip_op_ID = 1;
      tick();
      ip_ready = 1;
      tick();
      ip_ready = 0;
      #1 chk("t6_wait", 32'(state_dbg), 2);
      chk("t6_stall", 32'(ctl), 32'(C_STALL));
      #2 RST = 1'b1;
      #1 chk("t6_rst_ctl", 32'(ctl), 32'(C_NONE));
      chk("t6_rst_st", 32'(state_dbg), 0);
      chk("t6_rst_tmo", 32'(ip_timeout), 0);
      chk("t6_rst_cnt", 32'(stall_cycles), 0);
      clear_in();
      tick();
      RST = 1'b0;
      memread_EX = 1; rd_EX = 7; rs1_ID = 7; use_rs1_ID = 1;
      for (int c = 0; c < (1 << CNT_W) + 5; c++) tick();
      #1 chk("t6_sat", 32'(stall_cycles), 32'((1 << CNT_W) - 1));
      tick(); tick();
      #1 chk("t6_sat_hold", 32'(stall_cycles), 32'((1 << CNT_W) - 1));
      clear_in();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
